// File: rtl/inst_loader_if.sv
// Loader-side bus: control/status, inbound byte stream and outbound instruction write port.
// The loader itself uses the slave modport; whoever drives the program stream uses master.
`timescale 1ns/1ps
interface inst_loader_if #(
  parameter int A = 10,
  parameter int W = 9
);
  logic         load_start;
  logic [A:0]   load_count;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_ready;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic         busy;
  logic         done;
  logic         err;

  modport master (
    output load_start, load_count, byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, busy, done, err
  );

  modport slave (
    input  load_start, load_count, byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/inst_loader.sv
// Program loader: packs pairs of stream bytes (low byte first) into W-bit instructions
// and writes them to sequential instruction-memory addresses starting at 0.
`timescale 1ns/1ps
module inst_loader #(
  parameter int A = 10,
  parameter int W = 9
) (
  input logic          clk,
  input logic          rst,
  inst_loader_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_WRITE, S_DONE} state_t;

  localparam logic [A:0]   DEPTH    = {1'b1, {A{1'b0}}};
  localparam logic [A:0]   CNT_ONE  = (A+1)'(1);
  localparam logic [A-1:0] ADDR_ONE = A'(1);

  state_t     state, state_nxt;
  logic [A:0] remaining;
  logic [A:0] count_clamped;
  logic       hs;
  logic       hi_bad;

  assign count_clamped = (bus.load_count > DEPTH) ? DEPTH : bus.load_count;
  assign hs            = bus.byte_valid && bus.byte_ready;

  // High-byte bits that do not fit into the instruction word; none exist at W=16.
  generate
    if (W < 16) begin : g_hi_chk
      assign hi_bad = |bus.byte_in[7:W-8];
    end else begin : g_hi_nochk
      assign hi_bad = 1'b0;
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.load_start) state_nxt = (count_clamped == '0) ? S_DONE : S_LO;
      S_LO:    if (hs) state_nxt = S_HI;
      S_HI:    if (hs) state_nxt = S_WRITE;
      S_WRITE: state_nxt = (remaining == CNT_ONE) ? S_DONE : S_LO;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.byte_ready = (state == S_LO) || (state == S_HI);
    bus.wr_en      = (state == S_WRITE);
    bus.done       = (state == S_DONE);
    bus.busy       = (state != S_IDLE);
  end

  // Datapath: word assembly, address/count bookkeeping and the sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining   <= '0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.load_start) begin
            remaining   <= count_clamped;
            bus.wr_addr <= '0;
            bus.err     <= 1'b0;
          end
        end
        S_LO: begin
          if (hs) bus.wr_data[7:0] <= bus.byte_in;
        end
        S_HI: begin
          if (hs) begin
            bus.wr_data[W-1:8] <= bus.byte_in[W-9:0];
            if (hi_bad) bus.err <= 1'b1;
          end
        end
        S_WRITE: begin
          remaining <= remaining - CNT_ONE;
          // Last word keeps its address so a full-depth load never wraps to 0.
          if (remaining != CNT_ONE) bus.wr_addr <= bus.wr_addr + ADDR_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: random byte streams and handshake gaps compared
// against a list-based model of the expected instruction writes.
`timescale 1ns/1ps
module tb_inst_loader;
  localparam int A     = 4;
  localparam int W     = 9;
  localparam int DEPTH = 1 << A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] stim[$];

  inst_loader_if #(.A(A), .W(W)) bus();

  inst_loader #(.A(A), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_rdy"},  32'(bus.byte_ready), 0);
    check({pfx, "_wren"}, 32'(bus.wr_en), 0);
    check({pfx, "_addr"}, 32'(bus.wr_addr), 0);
    check({pfx, "_data"}, 32'(bus.wr_data), 0);
    check({pfx, "_busy"}, 32'(bus.busy), 0);
    check({pfx, "_done"}, 32'(bus.done), 0);
    check({pfx, "_err"},  32'(bus.err), 0);
  endtask

  // One load: start pulse, random-gap byte stream, collect writes, compare with model.
  // abort_after > 0 asserts reset asynchronously right after that many writes.
  task automatic run_load(input int cnt, input int valid_pct, input bit pulse_mid,
                          input int abort_after);
    int n, idx, done_cyc, last_wr, done_cnt, busy_cyc, lo, hi;
    bit overlap, exp_err, finished;
    int obs_addr[$];
    int obs_data[$];
    n        = (cnt > DEPTH) ? DEPTH : cnt;
    idx      = 0;
    done_cyc = -1;
    last_wr  = -1;
    done_cnt = 0;
    busy_cyc = 0;
    overlap  = 1'b0;
    finished = 1'b0;
    while (stim.size() < 2 * n) stim.push_back(8'($urandom));
    exp_err = 1'b0;
    for (int i = 0; i < n; i++)
      if ((int'(stim[2*i+1]) >> (W - 8)) != 0) exp_err = 1'b1;

    @(negedge clk);
    bus.load_start = 1'b1;
    bus.load_count = (A+1)'(cnt);
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'hEE;

    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      @(negedge clk);
      bus.load_start = pulse_mid && (cyc == 5);
      if (pulse_mid) bus.load_count = (A+1)'($urandom_range(1, 3));
      if (cyc == 0) check("err_clr", 32'(bus.err), 0);
      if (bus.wr_en) begin
        obs_addr.push_back(int'(bus.wr_addr));
        obs_data.push_back(int'(bus.wr_data));
        last_wr = cyc;
        if (bus.byte_ready) overlap = 1'b1;
      end
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        finished = 1'b1;
      end
      if (abort_after > 0 && bus.wr_en && obs_addr.size() == abort_after) begin
        #2 rst = 1'b1;
        #1 check_all_zero("abort");
        repeat (2) begin
          @(negedge clk);
          check("abort_nodone", 32'(bus.done), 0);
          check("abort_idle", 32'(bus.busy), 0);
        end
        rst = 1'b0;
        stim.delete();
        return;
      end
      bus.byte_valid = ($urandom_range(99) < valid_pct);
      bus.byte_in    = (idx < stim.size()) ? stim[idx] : 8'($urandom);
      #1;
      if (bus.byte_valid && bus.byte_ready) idx++;
    end

    check("finished", 32'(finished), 1);
    check("n_writes", 32'(obs_addr.size()), 32'(n));
    for (int i = 0; i < n && i < obs_addr.size(); i++) begin
      lo = int'(stim[2*i]);
      hi = int'(stim[2*i+1]);
      check($sformatf("addr%0d", i), 32'(obs_addr[i]), 32'(i));
      check($sformatf("data%0d", i), 32'(obs_data[i]),
            32'(((hi & ((1 << (W - 8)) - 1)) << 8) | lo));
    end
    check("done_cnt", 32'(done_cnt), 1);
    check("done_at", 32'(done_cyc), (n == 0) ? 0 : 32'(last_wr + 1));
    check("bytes_used", 32'(idx), 32'(2 * n));
    check("rdy_in_write", 32'(overlap), 0);
    if (valid_pct >= 100) check("busy_cycles", 32'(busy_cyc), 32'(3 * n + 1));
    @(negedge clk);
    check("busy_off", 32'(bus.busy), 0);
    check("done_off", 32'(bus.done), 0);
    check("err_final", 32'(bus.err), 32'(exp_err));
    stim.delete();
  endtask

  initial begin
    bus.load_start = 1'b0;
    bus.load_count = '0;
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed: three words on a continuous stream.
    stim = '{8'h01, 8'h00, 8'hFF, 8'h01, 8'h2A, 8'h00};
    run_load(3, 100, 1'b0, 0);

    // Empty program.
    run_load(0, 100, 1'b0, 0);

    // Out-of-range high byte sets the sticky error; the next start clears it.
    stim = '{8'h55, 8'h03};
    run_load(1, 100, 1'b0, 0);
    repeat (3) @(negedge clk);
    check("err_hold", 32'(bus.err), 1);
    stim = '{8'h11, 8'h00, 8'h22, 8'h01};
    run_load(2, 100, 1'b0, 0);

    // Gapped stream.
    stim = '{8'h10, 8'h00, 8'h20, 8'h01, 8'h30, 8'h00, 8'h40, 8'h01};
    run_load(4, 50, 1'b0, 0);

    // Asynchronous abort after two words, then a clean restart.
    run_load(5, 100, 1'b0, 2);
    run_load(3, 100, 1'b0, 0);

    // Full depth and over-range count, with a stray start pulse mid-load.
    run_load(DEPTH, 100, 1'b1, 0);
    run_load(25, 70, 1'b1, 0);

    repeat (8) run_load($urandom_range(0, 31), $urandom_range(30, 100),
                        1'($urandom_range(0, 1)), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
